// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// alu_arbiter
// Shares one combinational ALU between two requesters: port 0 (core execute
// stage) and port 1 (debug/test engine). A request is granted round-robin in
// IDLE, its control code and operands are registered onto the ALU inputs, the
// ALU result and zero flag are captured one cycle later, and the result is
// returned on a valid/ready response channel to the port that issued it.
//
// Ports
//   Clock                 rising-edge clock
//   Reset                 synchronous, active-high reset
//   ReqValid0/1           request valid, per port
//   ReqCtrl0/1            ALU control code, per port
//   ReqA0/1, ReqB0/1      operands, per port
//   ReqReady0/1           request accepted on the coming edge (IDLE only)
//   RespValid0/1          response valid for the port that was granted
//   RespReady0/1          response consumed, per port
//   RespData, RespZero    captured ALU result and zero flag (shared)
//   AluCtrl, AluA, AluB   registered ALU inputs
//   AluResult, AluZero    combinational ALU outputs
//   Busy                  an operation is in EXEC or RESP
module alu_arbiter #(
  parameter int WIDTH  = 24,
  parameter int CTRL_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid0,
  input  logic [CTRL_W-1:0] ReqCtrl0,
  input  logic [WIDTH-1:0]  ReqA0,
  input  logic [WIDTH-1:0]  ReqB0,
  output logic              ReqReady0,
  input  logic              ReqValid1,
  input  logic [CTRL_W-1:0] ReqCtrl1,
  input  logic [WIDTH-1:0]  ReqA1,
  input  logic [WIDTH-1:0]  ReqB1,
  output logic              ReqReady1,
  output logic              RespValid0,
  output logic              RespValid1,
  input  logic              RespReady0,
  input  logic              RespReady1,
  output logic [WIDTH-1:0]  RespData,
  output logic              RespZero,
  output logic [CTRL_W-1:0] AluCtrl,
  output logic [WIDTH-1:0]  AluA,
  output logic [WIDTH-1:0]  AluB,
  input  logic [WIDTH-1:0]  AluResult,
  input  logic              AluZero,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;  // port granted most recently; the other port wins a tie
  logic   owner;       // port whose operation is in flight
  logic   take0;
  logic   take1;
  logic   resp_done;

  // The owner's RespReady ends the response; the other port's is ignored.
  assign resp_done = owner ? RespReady1 : RespReady0;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    take0      = 1'b0;
    take1      = 1'b0;
    case (state)
      IDLE: begin
        if (ReqValid0 && ReqValid1) begin
          take0 = last_grant;
          take1 = ~last_grant;
        end else begin
          take0 = ReqValid0;
          take1 = ReqValid1;
        end
        if (take0 || take1) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: if (resp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset overrides the grant so no handshake completes on a reset edge.
  assign ReqReady0  = take0 && !Reset;
  assign ReqReady1  = take1 && !Reset;
  assign RespValid0 = (state == RESP) && !owner;
  assign RespValid1 = (state == RESP) && owner;
  assign Busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      AluCtrl    <= '0;
      AluA       <= '0;
      AluB       <= '0;
      RespData   <= '0;
      RespZero   <= 1'b0;
    end else begin
      state <= state_next;
      // ALU inputs are loaded only on a grant and otherwise keep the last
      // operation's values, so the ALU output stays stable through RESP.
      if (take0) begin
        AluCtrl    <= ReqCtrl0;
        AluA       <= ReqA0;
        AluB       <= ReqB0;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (take1) begin
        AluCtrl    <= ReqCtrl1;
        AluA       <= ReqA1;
        AluB       <= ReqB1;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end
      if (state == EXEC) begin
        RespData <= AluResult;
        RespZero <= AluZero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// tb_alu_arbiter
// Drives alu_arbiter with directed scenarios and randomized traffic. A small
// ALU stub closes the loop on AluResult/AluZero; a transaction-level model of
// the arbiter (free/busy, owner, round-robin preference) predicts handshakes
// and response contents cycle by cycle.
module tb_alu_arbiter;
  localparam int WIDTH  = 24;
  localparam int CTRL_W = 4;

  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic              ReqValid0 = 1'b0, ReqValid1 = 1'b0;
  logic [CTRL_W-1:0] ReqCtrl0 = '0, ReqCtrl1 = '0;
  logic [WIDTH-1:0]  ReqA0 = '0, ReqB0 = '0, ReqA1 = '0, ReqB1 = '0;
  logic              ReqReady0, ReqReady1;
  logic              RespValid0, RespValid1;
  logic              RespReady0 = 1'b0, RespReady1 = 1'b0;
  logic [WIDTH-1:0]  RespData;
  logic              RespZero;
  logic [CTRL_W-1:0] AluCtrl;
  logic [WIDTH-1:0]  AluA, AluB;
  logic [WIDTH-1:0]  AluResult;
  logic              AluZero;
  logic              Busy;

  int total = 0;
  int bad   = 0;

  // arbiter model state
  bit               m_busy;
  int               m_owner;
  int               m_last;
  int               m_due;   // cycles until the response becomes visible
  logic [WIDTH-1:0] m_data;
  logic             m_zero;

  always #5 Clock = ~Clock;

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .ReqValid0(ReqValid0), .ReqCtrl0(ReqCtrl0), .ReqA0(ReqA0), .ReqB0(ReqB0),
    .ReqReady0(ReqReady0),
    .ReqValid1(ReqValid1), .ReqCtrl1(ReqCtrl1), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .ReqReady1(ReqReady1),
    .RespValid0(RespValid0), .RespValid1(RespValid1),
    .RespReady0(RespReady0), .RespReady1(RespReady1),
    .RespData(RespData), .RespZero(RespZero),
    .AluCtrl(AluCtrl), .AluA(AluA), .AluB(AluB),
    .AluResult(AluResult), .AluZero(AluZero),
    .Busy(Busy)
  );

  function automatic logic [WIDTH-1:0] alu_fn(input logic [CTRL_W-1:0] c,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b1010: return a - b;
      4'b0111: return (a < b) ? WIDTH'(1) : WIDTH'(0);
      4'b1100: return ~(a | b);
      default: return a;
    endcase
  endfunction

  assign AluResult = alu_fn(AluCtrl, AluA, AluB);
  assign AluZero   = (AluResult == '0);

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    ReqValid0 = 0; ReqValid1 = 0; RespReady0 = 0; RespReady1 = 0;
    ReqCtrl0 = '0; ReqA0 = '0; ReqB0 = '0;
    ReqCtrl1 = '0; ReqA1 = '0; ReqB1 = '0;
  endtask

  task automatic do_reset();
    Reset = 1;
    idle_inputs();
    step();
    step();
    Reset   = 0;
    m_busy  = 0;
    m_last  = 1;
    m_owner = 0;
    m_due   = 0;
  endtask

  function automatic logic [WIDTH-1:0] rand_opnd();
    if ($urandom_range(0, 1) == 1) return WIDTH'($urandom_range(0, 7));
    return WIDTH'($urandom);
  endfunction

  // Reset held two cycles with requests pending: everything reads zero.
  task automatic test_reset();
    Reset = 1;
    ReqValid0 = 1; ReqValid1 = 1; RespReady0 = 1; RespReady1 = 1;
    ReqCtrl0 = 4'b0010; ReqA0 = 24'h123456; ReqB0 = 24'h000001;
    step();
    step();
    @(negedge Clock);
    total++;
    if ({ReqReady0, ReqReady1, RespValid0, RespValid1, Busy, RespZero} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {ReqReady0, ReqReady1, RespValid0, RespValid1, Busy, RespZero});
    end
    total++;
    if ({RespData, AluCtrl, AluA, AluB} !== '0) begin
      bad++;
      $display("FAIL reset_data got data=%h ctrl=%h a=%h b=%h want all 0",
               RespData, AluCtrl, AluA, AluB);
    end
    do_reset();
  endtask

  // One port-0 add: grant, EXEC, response, back to IDLE with operands kept.
  task automatic test_single_op();
    do_reset();
    ReqValid0 = 1; ReqCtrl0 = 4'b0010; ReqA0 = 24'h000005; ReqB0 = 24'h000003;
    RespReady0 = 1;
    @(negedge Clock);
    total++;
    if ({ReqReady0, ReqReady1, Busy} !== 3'b100) begin
      bad++;
      $display("FAIL single_grant got rdy0,rdy1,busy=%b want=100", {ReqReady0, ReqReady1, Busy});
    end
    step();
    ReqValid0 = 0;
    @(negedge Clock);
    total++;
    if ({Busy, RespValid0, AluCtrl, AluA, AluB} !== {1'b1, 1'b0, 4'b0010, 24'h000005, 24'h000003}) begin
      bad++;
      $display("FAIL single_exec got busy=%b rv0=%b ctrl=%h a=%h b=%h",
               Busy, RespValid0, AluCtrl, AluA, AluB);
    end
    step();
    @(negedge Clock);
    total++;
    if ({RespValid0, RespValid1, RespData, RespZero} !== {1'b1, 1'b0, 24'h000008, 1'b0}) begin
      bad++;
      $display("FAIL single_resp got rv0=%b rv1=%b data=%h zero=%b want 1 0 000008 0",
               RespValid0, RespValid1, RespData, RespZero);
    end
    step();
    @(negedge Clock);
    total++;
    if ({Busy, RespValid0, AluA, AluB} !== {1'b0, 1'b0, 24'h000005, 24'h000003}) begin
      bad++;
      $display("FAIL single_idle got busy=%b rv0=%b a=%h b=%h want 0 0 000005 000003",
               Busy, RespValid0, AluA, AluB);
    end
  endtask

  // Port-1 response stalled 5 cycles while port 0 waits; port 0 follows.
  task automatic test_backpressure();
    do_reset();
    ReqValid1 = 1; ReqCtrl1 = 4'b0010; ReqA1 = 24'h000007; ReqB1 = 24'h000009;
    @(negedge Clock);
    total++;
    if ({ReqReady0, ReqReady1} !== 2'b01) begin
      bad++;
      $display("FAIL bp_grant1 got rdy0,rdy1=%b want=01", {ReqReady0, ReqReady1});
    end
    step();
    ReqValid1 = 0;
    ReqValid0 = 1; ReqCtrl0 = 4'b0010; ReqA0 = 24'h000001; ReqB0 = 24'h000002;
    RespReady0 = 1;  // must be ignored while port 1 owns the response
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      total++;
      if ({RespValid1, RespValid0, ReqReady0, RespData} !== {1'b1, 1'b0, 1'b0, 24'h000010}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got rv1=%b rv0=%b rdy0=%b data=%h want 1 0 0 000010",
                 i, RespValid1, RespValid0, ReqReady0, RespData);
      end
      step();
    end
    RespReady1 = 1;
    step();
    @(negedge Clock);
    total++;
    if ({ReqReady0, ReqReady1, RespValid1} !== 3'b100) begin
      bad++;
      $display("FAIL bp_release got rdy0,rdy1,rv1=%b want=100", {ReqReady0, ReqReady1, RespValid1});
    end
    step();
    ReqValid0 = 0;
    step();
    @(negedge Clock);
    total++;
    if ({RespValid0, RespData} !== {1'b1, 24'h000003}) begin
      bad++;
      $display("FAIL bp_port0_resp got rv0=%b data=%h want 1 000003", RespValid0, RespData);
    end
    step();
  endtask

  // Reset during EXEC of a port-0 op drops it; the next tie goes to port 0.
  task automatic test_reset_mid_exec();
    do_reset();
    ReqValid0 = 1; ReqCtrl0 = 4'b0001; ReqA0 = 24'h0000f0; ReqB0 = 24'h00000f;
    RespReady0 = 1;
    step();
    ReqValid0 = 0;
    @(negedge Clock);
    total++;
    if (Busy !== 1'b1) begin
      bad++;
      $display("FAIL rme_exec got busy=%b want=1", Busy);
    end
    Reset = 1; ReqValid0 = 1; ReqValid1 = 1;
    ReqCtrl1 = 4'b0010; ReqA1 = 24'h000002; ReqB1 = 24'h000002;
    #1;
    total++;
    if ({ReqReady0, ReqReady1} !== 2'b00) begin
      bad++;
      $display("FAIL rme_ready_in_reset got=%b want=00", {ReqReady0, ReqReady1});
    end
    step();
    Reset = 0;
    @(negedge Clock);
    total++;
    if ({RespValid0, RespValid1, Busy, ReqReady0, ReqReady1} !== 5'b00010) begin
      bad++;
      $display("FAIL rme_after got rv0,rv1,busy,rdy0,rdy1=%b want=00010",
               {RespValid0, RespValid1, Busy, ReqReady0, ReqReady1});
    end
    step();
    ReqValid0 = 0; ReqValid1 = 0;
    step();
    step();
  endtask

  // Cycle-by-cycle traffic against the model. p0/p1 are request-valid
  // percentages, prr the response-ready percentage; fixed uses the
  // add 1+1 (port 0) / sub 4-4 (port 1) payloads.
  task automatic run_traffic(input int n, input int p0, input int p1, input int prr,
                             input bit fixed, input string tag);
    int pick;
    bit rr [2];
    for (int cyc = 0; cyc < n; cyc++) begin
      ReqValid0 = ($urandom_range(0, 99) < p0);
      ReqValid1 = ($urandom_range(0, 99) < p1);
      if (fixed) begin
        ReqCtrl0 = 4'b0010; ReqA0 = 24'd1; ReqB0 = 24'd1;
        ReqCtrl1 = 4'b1010; ReqA1 = 24'd4; ReqB1 = 24'd4;
      end else begin
        ReqCtrl0 = CTRL_W'($urandom); ReqA0 = rand_opnd(); ReqB0 = rand_opnd();
        ReqCtrl1 = CTRL_W'($urandom); ReqA1 = rand_opnd(); ReqB1 = rand_opnd();
      end
      RespReady0 = ($urandom_range(0, 99) < prr);
      RespReady1 = ($urandom_range(0, 99) < prr);
      rr[0] = RespReady0;
      rr[1] = RespReady1;
      @(negedge Clock);
      pick = -1;
      if (!m_busy) begin
        if (ReqValid0 && ReqValid1) pick = 1 - m_last;
        else if (ReqValid0)         pick = 0;
        else if (ReqValid1)         pick = 1;
      end
      total++;
      if ({ReqReady0, ReqReady1} !== {pick == 0, pick == 1}) begin
        bad++;
        $display("FAIL %s_ready cyc=%0d got rdy0,rdy1=%b want=%b", tag, cyc,
                 {ReqReady0, ReqReady1}, {pick == 0, pick == 1});
      end
      total++;
      if ({RespValid0, RespValid1, Busy} !==
          {m_busy && m_due == 0 && m_owner == 0, m_busy && m_due == 0 && m_owner == 1, m_busy}) begin
        bad++;
        $display("FAIL %s_resp_valid cyc=%0d got rv0,rv1,busy=%b want=%b", tag, cyc,
                 {RespValid0, RespValid1, Busy},
                 {m_busy && m_due == 0 && m_owner == 0, m_busy && m_due == 0 && m_owner == 1, m_busy});
      end
      if (m_busy && m_due == 0) begin
        total++;
        if ({RespData, RespZero} !== {m_data, m_zero}) begin
          bad++;
          $display("FAIL %s_resp_data cyc=%0d port=%0d got data=%h zero=%b want data=%h zero=%b",
                   tag, cyc, m_owner, RespData, RespZero, m_data, m_zero);
        end
      end
      if (pick >= 0) begin
        m_busy  = 1;
        m_owner = pick;
        m_last  = pick;
        m_due   = 1;
        m_data  = (pick == 0) ? alu_fn(ReqCtrl0, ReqA0, ReqB0) : alu_fn(ReqCtrl1, ReqA1, ReqB1);
        m_zero  = (m_data == '0);
      end else if (m_busy && m_due > 0) begin
        m_due = 0;
      end else if (m_busy && rr[m_owner]) begin
        m_busy = 0;
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    do_reset();
    run_traffic(40, 100, 100, 100, 1'b1, "fair");
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_traffic(30, 0, 100, 100, 1'b0, "b2b");
  endtask

  task automatic test_random();
    do_reset();
    run_traffic(400, 60, 60, 60, 1'b0, "rand");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_op();
    test_fairness();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
